// File: rtl/wash_sched.sv
// wash_sched: laundromat wash-program scheduler with BCD pricing.
//
// A job runs WASH -> RINSE -> SPIN (or SPIN only for the dry program) and
// counts down on 1-second ticks. It then waits in DONE for the door to be
// opened. Once the grace period has run out, every further second adds a
// fine to the job's charge. Opening the door moves the charge into profit.
// All money and time values are 3-digit BCD and saturate at 999.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   on_i                enable; low freezes every register
//   tick_i              one-cycle 1-second strobe
//   start_i, sel_i      start request and program select (0 dry .. 3 big)
//   pickup_i            door-open pulse that ends a finished job
//   *_price_i           BCD price per program
//   setfine_i           BCD fine per overdue second
//   phase_o             0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE
//   remain_o            BCD seconds left in the program
//   charge_o            BCD amount owed for the current job
//   profit_o            BCD total collected since reset
//   runtime_o           BCD total seconds spent washing since reset
//   busy_o              any phase other than IDLE
//   alarm_o             DONE with the grace period expired
//
// state | meaning
// IDLE  | no job, waiting for start
// WASH  | wash phase counting down
// RINSE | rinse phase counting down
// SPIN  | spin phase counting down (dry program starts here)
// DONE  | finished, waiting for pickup; fines after grace period
module wash_sched #(
    parameter int WASH_T  = 8,
    parameter int RINSE_T = 5,
    parameter int SPIN_T  = 4,
    parameter int GRACE_T = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on_i,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic [1:0]  sel_i,
    input  logic        pickup_i,
    input  logic [11:0] dy_price_i,
    input  logic [11:0] s_price_i,
    input  logic [11:0] m_price_i,
    input  logic [11:0] b_price_i,
    input  logic [11:0] setfine_i,
    output logic [2:0]  phase_o,
    output logic [11:0] remain_o,
    output logic [11:0] charge_o,
    output logic [11:0] profit_o,
    output logic [11:0] runtime_o,
    output logic        busy_o,
    output logic        alarm_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    // Digit-wise BCD add; any carry out of the hundreds digit clamps to 999.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
        logic [4:0]  s;
        logic        c;
        logic [11:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        if (c) r = 12'h999;
        return r;
    endfunction

    // BCD decrement with per-digit borrow; holds at 000.
    function automatic logic [11:0] bcd_dec(input logic [11:0] a);
        logic [11:0] r;
        logic        b;
        r = a;
        b = (a != 12'h000);
        for (int i = 0; i < 3; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [11:0] SPIN_BCD  = to_bcd(SPIN_T);
    localparam logic [11:0] TOTAL_BCD = to_bcd(WASH_T + RINSE_T + SPIN_T);
    localparam logic [6:0]  WASH_C    = 7'(WASH_T);
    localparam logic [6:0]  RINSE_C   = 7'(RINSE_T);
    localparam logic [6:0]  SPIN_C    = 7'(SPIN_T);
    localparam logic [15:0] GRACE_C   = 16'(GRACE_T);

    state_t      state_q, state_d;
    logic [11:0] remain_q, remain_d;
    logic [11:0] charge_q, charge_d;
    logic [11:0] profit_q, profit_d;
    logic [11:0] runtime_q, runtime_d;
    logic        busy_q, busy_d;
    logic        alarm_q, alarm_d;
    logic [6:0]  pcnt_q, pcnt_d;
    logic [15:0] over_q, over_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            charge_q  <= '0;
            profit_q  <= '0;
            runtime_q <= '0;
            busy_q    <= 1'b0;
            alarm_q   <= 1'b0;
            pcnt_q    <= '0;
            over_q    <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            charge_q  <= charge_d;
            profit_q  <= profit_d;
            runtime_q <= runtime_d;
            busy_q    <= busy_d;
            alarm_q   <= alarm_d;
            pcnt_q    <= pcnt_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        charge_d  = charge_q;
        profit_d  = profit_q;
        runtime_d = runtime_q;
        alarm_d   = alarm_q;
        pcnt_d    = pcnt_q;
        over_d    = over_q;

        if (on_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        case (sel_i)
                            2'd0:    charge_d = dy_price_i;
                            2'd1:    charge_d = s_price_i;
                            2'd2:    charge_d = m_price_i;
                            default: charge_d = b_price_i;
                        endcase
                        if (sel_i == 2'd0) begin
                            state_d  = S_SPIN;
                            remain_d = SPIN_BCD;
                            pcnt_d   = SPIN_C;
                        end else begin
                            state_d  = S_WASH;
                            remain_d = TOTAL_BCD;
                            pcnt_d   = WASH_C;
                        end
                    end
                end
                S_WASH, S_RINSE, S_SPIN: begin
                    if (tick_i) begin
                        remain_d  = bcd_dec(remain_q);
                        runtime_d = bcd_add_sat(runtime_q, 12'h001);
                        pcnt_d    = pcnt_q - 7'd1;
                        // Counter is on its last second: leave the phase on this tick.
                        if (pcnt_q <= 7'd1) begin
                            if (state_q == S_WASH) begin
                                state_d = S_RINSE;
                                pcnt_d  = RINSE_C;
                            end else if (state_q == S_RINSE) begin
                                state_d = S_SPIN;
                                pcnt_d  = SPIN_C;
                            end else begin
                                state_d  = S_DONE;
                                remain_d = 12'h000;
                                pcnt_d   = '0;
                                over_d   = '0;
                                alarm_d  = (GRACE_C == 16'd0);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (pickup_i) begin
                        profit_d = bcd_add_sat(profit_q, charge_q);
                        charge_d = 12'h000;
                        alarm_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else if (tick_i) begin
                        // Fines start on the tick after the alarm rises.
                        if (alarm_q) charge_d = bcd_add_sat(charge_q, setfine_i);
                        if (over_q < GRACE_C) begin
                            over_d = over_q + 16'd1;
                            if (over_q + 16'd1 >= GRACE_C) alarm_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign phase_o   = state_q;
    assign remain_o  = remain_q;
    assign charge_o  = charge_q;
    assign profit_o  = profit_q;
    assign runtime_o = runtime_q;
    assign busy_o    = busy_q;
    assign alarm_o   = alarm_q;

endmodule
